// File: rtl/csc_mode_ctrl.sv
// Frame-synchronous CSC mode controller: holds mode requests until the
// next vsync rising edge, then blanks the output while the pipeline refills.
module csc_mode_ctrl #(
  parameter logic [1:0]  RST_MODE     = 2'b00,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [1:0]       req_mode,
  output logic             req_ready,
  input  logic             vsync,
  output logic [1:0]       Mode,
  output logic             blank,
  output logic             pend,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  localparam bit NO_FLUSH = (FLUSH_CYCLES == 0);
  localparam logic [3:0] FLUSH_LAST =
    NO_FLUSH ? 4'd0 : 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             blank_q, blank_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;

  logic vs_rise;
  logic hs;
  logic illegal;
  logic start;
  logic apply;
  logic flush_done;

  assign vs_rise    = vsync & ~vsync_q;
  assign req_ready  = (state_q == S_IDLE);
  assign hs         = req_valid & req_ready;
  assign illegal    = hs & (req_mode == 2'b11);
  assign start      = hs & ~illegal & (req_mode != mode_q);
  assign apply      = (state_q == S_WAIT_VS) & vs_rise;
  assign flush_done = (state_q == S_FLUSH) & (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_rise) state_d = NO_FLUSH ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pend_d      = pend_q;
    blank_d     = blank_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    unique case (1'b1)
      start: begin
        pend_mode_d = req_mode;
        pend_d      = 1'b1;
      end
      apply: begin
        mode_d  = pend_mode_q;
        pend_d  = 1'b0;
        blank_d = ~NO_FLUSH;
        cnt_d   = FLUSH_LAST;
      end
      flush_done: begin
        blank_d = 1'b0;
      end
      default: begin
        if (state_q == S_FLUSH) cnt_d = cnt_q - 4'd1;
      end
    endcase

    // A rise that applies a switch restarts the count; others saturate up.
    if (apply) begin
      frame_cnt_d = '0;
    end else if (vs_rise && frame_cnt_q != CNT_MAX) begin
      frame_cnt_d = frame_cnt_q + CNT_ONE;
    end

    if (illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      mode_q      <= RST_MODE;
      pend_mode_q <= RST_MODE;
      pend_q      <= 1'b0;
      blank_q     <= 1'b0;
      cnt_q       <= 4'd0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      blank_q     <= blank_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign Mode      = mode_q;
  assign blank     = blank_q;
  assign pend      = pend_q;
  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

endmodule

// File: doc/csc_mode_ctrl.md
# csc_mode_ctrl

Frame-synchronous mode controller for the colour-space-conversion datapath. Accepts mode-change requests over a valid/ready handshake and holds each one pending until the next vsync rising edge, so a frame is never converted with mixed modes. After each switch it raises a blank strobe for a programmable number of cycles while the CSC pipeline registers refill. It sits between the register/control interface and the CSC `Mode` input; the `vsync` input is tapped from `DPi[26]`.

## Interface
- `RST_MODE`, 2'b00: mode driven after reset (00 RGB→YUV, 01 YUV→RGB, 10 round-trip).
- `FLUSH_CYCLES`, 2: blank length after a switch; legal range 0..15.
- `CNT_W`, 16: width of `frame_cnt`.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  mode-change request valid.
- `req_mode`  in  2  requested mode; 2'b11 is reserved (illegal).
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `vsync`  in  1  input-stream vsync (`DPi[26]`).
- `Mode`  out  2  registered; drives the CSC `Mode`.
- `blank`  out  1  registered; downstream gates `den` while high.
- `pend`  out  1  high while an accepted request waits for vsync.
- `frame_cnt`  out  `CNT_W`  vsync rises since the last applied switch, saturating.
- `err`  out  1  sticky; set by an illegal request.
- `err_clr`  in  1  clears `err`.

## Operation
- Edge detect: `vsync_d <= vsync` (reset 0); `vs_rise = vsync & ~vsync_d`.
- FSM states: IDLE, WAIT_VS, FLUSH. Reset state is IDLE.
- `req_ready` = (state == IDLE), combinational from state.
- IDLE, on handshake:
  - `req_mode == 2'b11`: request consumed, `err <= 1`, stay IDLE, `Mode` unchanged.
  - `req_mode == Mode`: request consumed, no-op, stay IDLE, no blank.
  - otherwise: `pend_mode <= req_mode`, `pend <= 1`, go to WAIT_VS.
- WAIT_VS, on `vs_rise`:
  - `Mode <= pend_mode`, `pend <= 0`, `frame_cnt <= 0`.
  - If `FLUSH_CYCLES == 0`: go to IDLE with no blank.
  - Otherwise: `blank <= 1`, `cnt <= FLUSH_CYCLES-1`, go to FLUSH.
- FLUSH:
  - `cnt == 0`: `blank <= 0`, go to IDLE.
  - else: `cnt <= cnt - 1`.
- `frame_cnt`: increments on every `vs_rise` that does not apply a switch; holds at all-ones.
- `err`: if `err_clr` and an illegal handshake occur in the same cycle, set wins.

## Timing
- Reset values: `Mode = RST_MODE`, `blank = 0`, `pend = 0`, `frame_cnt = 0`, `err = 0`, `req_ready = 1`. Pending request discarded.
- Reset mid-WAIT_VS or mid-FLUSH: the pending or in-flight switch is lost, `Mode` returns to `RST_MODE`, `blank` drops asynchronously.
- Switch latency: `Mode` and `blank` change at the first clock edge sampling `vsync = 1` after a low sample.
- `blank` stays high for exactly `FLUSH_CYCLES` cycles.
- `req_ready` returns 1 in the cycle after `blank` falls, or after the applying edge when `FLUSH_CYCLES == 0`.
- Request accepted on the same edge as a `vs_rise` while in IDLE:
  - not applied to that frame; it waits for the next rise.
  - that rise increments `frame_cnt`.
- `vs_rise` during FLUSH: increments `frame_cnt`; does not restart the flush.
- `vsync` held high across the acceptance: no edge, so the request waits for the next low→high transition.

## Test plan
- Reset with `RST_MODE = 0`; request 2'b10 at cycle 5; vsync rises at cycle 20 → `pend` high cycles 6–20, `Mode = 2'b10` after cycle 20 edge, `blank` high 2 cycles, `req_ready` back at cycle 23, `frame_cnt = 0`.
- Request 2'b11 → `err = 1`, `Mode` unchanged, `req_ready` stays 1; `err_clr` together with a second 2'b11 → `err` stays 1; `err_clr` alone → `err = 0`.
- Request equal to the current `Mode` → consumed in one cycle, no `pend`, no `blank`, `frame_cnt` not reset.
- Request accepted on the same edge as a vsync rise → not applied until the following rise; `frame_cnt` goes 0→1 before the apply.
- `FLUSH_CYCLES = 0`: switch 00→01 at vsync → `blank` never asserts, `req_ready` high the next cycle; 70000 further vsync rises → `frame_cnt` saturates at 16'hFFFF.
- Assert `rst_n` low during FLUSH, and separately during WAIT_VS → all outputs return to their reset values immediately; no switch is applied after release until a new request.
